// File: rtl/mem_store_writer_if.sv
// Store request / byte-write port bundle for mem_store_writer.
// master = requester side, slave = the store writer.
interface mem_store_writer_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;
  logic [1:0]            req_size;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  done;
  logic                  err;
  logic                  busy;

  modport master (
    output req_valid, req_addr, req_data, req_size,
    input  req_ready, mem_we, mem_addr, mem_wdata, done, err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size,
    output req_ready, mem_we, mem_addr, mem_wdata, done, err, busy
  );
endinterface

// File: rtl/mem_store_writer.sv
// Serialises a byte/half/word store into big-endian byte writes, one per clock.
// Define MEM_STORE_ALIGN_CHECK_EN to reject misaligned half/word stores.
module mem_store_writer #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mem_store_writer_if.slave bus
);
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, WRITE, ERR} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [1:0]            cnt;
  logic [1:0]            last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BYTE_WIDTH-1:0] mem_wdata;
  logic                  done;
  logic                  err;
  logic                  busy;
  logic                  reject_c;
  logic [DATA_WIDTH-1:0] aligned_c;
  logic [1:0]            last_c;

  // Reject decode: reserved size always, misalignment only when checking is built in.
  always_comb begin
    reject_c = (bus.req_size == 2'b11);
`ifdef MEM_STORE_ALIGN_CHECK_EN
    if (bus.req_size == 2'b01 && bus.req_addr[0])
      reject_c = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
      reject_c = 1'b1;
`endif
  end

  // Left-justify the store so the first byte out is always shreg[31:24].
  always_comb begin
    aligned_c = bus.req_data;
    last_c    = 2'd3;
    case (bus.req_size)
      2'b00: begin
        aligned_c = {bus.req_data[7:0], 24'h0};
        last_c    = 2'd0;
      end
      2'b01: begin
        aligned_c = {bus.req_data[15:0], 16'h0};
        last_c    = 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      last      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            busy <= 1'b1;
            if (reject_c) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= bus.req_addr;
              mem_wdata <= aligned_c[31:24];
              shreg     <= aligned_c << 8;
              cnt       <= 2'd0;
              last      <= last_c;
              done      <= (last_c == 2'd0);
            end
          end
        end
        WRITE: begin
          if (cnt == last) begin
            state  <= IDLE;
            mem_we <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
          end else begin
            cnt       <= cnt + 2'd1;
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            mem_wdata <= shreg[31:24];
            shreg     <= shreg << 8;
            done      <= ((cnt + 2'd1) == last);
          end
        end
        ERR: begin
          state <= IDLE;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          done   <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_mem_store_writer.sv
// Directed bench for mem_store_writer: cycle-accurate byte sequence, error,
// wrap, reset-abort and (with MEM_STORE_ALIGN_CHECK_EN) alignment checks.
module tb_mem_store_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] mem [logic [31:0]];

  mem_store_writer_if #(.ADDR_WIDTH(32)) bus ();

  mem_store_writer #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model captures every byte write.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] a, input logic [8:0] exp);
    logic [8:0] v;
    v = mem.exists(a) ? {1'b0, mem[a]} : 9'h100;
    check(tag, 64'(v), 64'(exp));
  endtask

  // Issue one store and check every cycle until req_ready returns.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input bit exp_err);
    int k;
    int budget;
    logic [31:0] ea;
    logic [7:0]  eb;
    k = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    budget = 20;
    while (!bus.req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("ready_timeout", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_size  = size;
    @(posedge clk);
    #1;
    // Garbage while busy must be ignored.
    bus.req_addr = 32'h5A5A_5A5A;
    bus.req_data = 32'hFFFF_FFFF;
    bus.req_size = 2'b11;
    if (exp_err) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("err_pulse", 64'(bus.err), 64'd1);
      check("err_we", 64'(bus.mem_we), 64'd0);
      check("err_done", 64'(bus.done), 64'd0);
      check("err_ready", 64'(bus.req_ready), 64'd0);
      check("err_busy", 64'(bus.busy), 64'd1);
    end else begin
      for (int i = 0; i < k; i++) begin
        @(negedge clk);
        if (i == k - 1) bus.req_valid = 1'b0;
        ea = addr + 32'(i);
        eb = 8'(data >> (8 * (k - 1 - i)));
        check("wr_we", 64'(bus.mem_we), 64'd1);
        check("wr_addr", 64'(bus.mem_addr), 64'(ea));
        check("wr_data", 64'(bus.mem_wdata), 64'(eb));
        check("wr_done", 64'(bus.done), 64'(i == k - 1));
        check("wr_err", 64'(bus.err), 64'd0);
        check("wr_ready", 64'(bus.req_ready), 64'd0);
      end
    end
    @(negedge clk);
    check("end_ready", 64'(bus.req_ready), 64'd1);
    check("end_we", 64'(bus.mem_we), 64'd0);
    check("end_done", 64'(bus.done), 64'd0);
    check("end_err", 64'(bus.err), 64'd0);
    check("end_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = '0;
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_we", 64'(bus.mem_we), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);
    check("post_rst_addr", 64'(bus.mem_addr), 64'd0);
    check("post_rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("post_rst_done", 64'(bus.done), 64'd0);
    check("post_rst_err", 64'(bus.err), 64'd0);
    @(negedge clk);

    run_store(32'h0000_0100, 32'h1122_3344, 2'b10, 1'b0);
    check_mem("mem_100", 32'h100, 9'h11);
    check_mem("mem_101", 32'h101, 9'h22);
    check_mem("mem_102", 32'h102, 9'h33);
    check_mem("mem_103", 32'h103, 9'h44);
    check("idle_hold_addr", 64'(bus.mem_addr), 64'h103);
    check("idle_hold_data", 64'(bus.mem_wdata), 64'h44);

    run_store(32'h0000_0200, 32'h0000_ABCD, 2'b01, 1'b0);
    run_store(32'h0000_0300, 32'h0000_00EE, 2'b00, 1'b0);
    check_mem("mem_200", 32'h200, 9'hAB);
    check_mem("mem_201", 32'h201, 9'hCD);
    check_mem("mem_300", 32'h300, 9'hEE);

    mem.delete();
    run_store(32'h0000_0040, 32'hCAFE_F00D, 2'b11, 1'b1);
    check("err_no_writes", 64'(mem.num()), 64'd0);

`ifndef MEM_STORE_ALIGN_CHECK_EN
    run_store(32'hFFFF_FFFE, 32'hDEAD_BEEF, 2'b10, 1'b0);
    check_mem("wrap_fffffffe", 32'hFFFF_FFFE, 9'hDE);
    check_mem("wrap_ffffffff", 32'hFFFF_FFFF, 9'hAD);
    check_mem("wrap_0", 32'h0, 9'hBE);
    check_mem("wrap_1", 32'h1, 9'hEF);
`else
    mem.delete();
    run_store(32'h0000_0102, 32'h1122_3344, 2'b10, 1'b1);
    run_store(32'h0000_0103, 32'h0000_1234, 2'b01, 1'b1);
    check("align_no_writes", 64'(mem.num()), 64'd0);
    run_store(32'h0000_0104, 32'h0000_1234, 2'b01, 1'b0);
    check_mem("align_104", 32'h104, 9'h12);
    check_mem("align_105", 32'h105, 9'h34);
`endif

    // Reset in cycle N+2 aborts the word after its first byte.
    mem.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0100;
    bus.req_data  = 32'h1122_3344;
    bus.req_size  = 2'b10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_we", 64'(bus.mem_we), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_err", 64'(bus.err), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_addr", 64'(bus.mem_addr), 64'd0);
    check("abort_wdata", 64'(bus.mem_wdata), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(bus.req_ready), 64'd1);
    check("abort_done_after", 64'(bus.done), 64'd0);
    check_mem("abort_mem_100", 32'h100, 9'h11);
    check_mem("abort_mem_101", 32'h101, 9'h100);
    check("abort_mem_count", 64'(mem.num()), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_store_writer.md
Name: mem_store_writer

Overview:
- Write-side companion to the byte-addressed memory read path.
- Accepts one store request at a time: 32-bit data, address, size (byte/half/word).
- Serialises the store into byte writes on a byte-wide memory write port, one byte per clock.
- Byte order is big-endian, matching the read path: the byte at `addr` is the MSB of the stored quantity.

Parameters:
- ADDR_WIDTH, 32, width of the byte address; all address arithmetic is modulo 2^ADDR_WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_addr  input  ADDR_WIDTH  byte address of first byte
- req_data  input  32  store data; right-justified for byte/half
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- mem_we  output  1  byte write strobe
- mem_addr  output  ADDR_WIDTH  byte write address
- mem_wdata  output  8  byte write data
- done  output  1  one-cycle pulse, coincident with the last byte write
- err  output  1  one-cycle pulse, request rejected, no bytes written
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - req_ready = 1 after reset deasserts.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - done = 0, err = 0, busy = 0.
- Outputs: all outputs except req_ready are registered. req_ready = (state == IDLE) and not in reset.
- Acceptance: req_valid & req_ready at the rising edge of cycle N latches addr, data and size.
  - Inputs are ignored while busy.
- State machine:
  - IDLE -> WRITE on an accepted request with size 00/01/10.
  - IDLE -> ERR on an accepted request with size 11.
  - WRITE -> IDLE after the last byte is issued.
  - ERR -> IDLE after one cycle.
- Byte count k: byte = 1, half = 2, word = 4. A 2-bit byte counter runs 0..k-1.
- Write sequence: in cycles N+1 .. N+k, mem_we = 1 and mem_addr = addr + i for i = 0..k-1.
  - Word: bytes data[31:24], [23:16], [15:8], [7:0] in that order.
  - Half: data[15:8] then data[7:0].
  - Byte: data[7:0].
- Completion: done = 1 in cycle N+k only. req_ready returns high in cycle N+k+1.
  - Throughput: word 5, half 3, byte 2 cycles per request.
- Error path: size 11 gives err = 1 in cycle N+1, mem_we stays 0, req_ready high again at N+2.
- Address wrap: addr + i wraps modulo 2^ADDR_WIDTH, with no error.
- Idle outputs: while not writing, mem_we = 0; mem_addr and mem_wdata hold their last values.
- Reset mid-operation:
  - mem_we drops immediately (asynchronously) and the sequence is aborted.
  - Bytes already written remain in memory; no done or err is produced.
- done and err are never asserted in the same cycle.

Optional Feature:
- Macro: MEM_STORE_ALIGN_CHECK_EN.
- With the macro defined, misaligned requests are rejected:
  - A half with addr[0] != 0, or a word with addr[1:0] != 0, takes the ERR path (err pulse, no writes).
  - Byte stores are never misaligned.
- Without the macro, any address is accepted and written byte-serially as above, including wrap.

Test Plan:
- Word 0x11223344 at 0x100 accepted in cycle N -> mem writes 0x100=0x11, 0x101=0x22, 0x102=0x33, 0x103=0x44 in cycles N+1..N+4; done at N+4; req_ready at N+5.
- Half 0x0000ABCD at 0x200, then byte 0x000000EE at 0x300 back-to-back -> 0x200=0xAB, 0x201=0xCD, done; next accept -> 0x300=0xEE, done one cycle after its accept.
- Word 0xDEADBEEF at 0xFFFFFFFE, macro off -> writes to 0xFFFFFFFE=0xDE, 0xFFFFFFFF=0xAD, 0x0=0xBE, 0x1=0xEF; no err.
- req_size = 11 at 0x40 -> err pulse at N+1, mem_we never high, req_ready high at N+2.
- Word store at 0x100, rst asserted in cycle N+2 -> mem_we 0 immediately; only 0x100 written; all outputs at reset values; no done.
- Macro on: word at 0x102 -> err, zero writes; half at 0x103 -> err; half at 0x104 -> normal two-byte write with done.
